// File: rtl/move_check_sched.sv
// Front-end scheduler for the board_validator piece checkers: pre-checks a move, dispatches it, returns a verdict.
// Optional MOVE_SCHED_TURN_CHECK_EN enables the wrong-turn pre-check (code 3).
module move_check_sched #(
  parameter int unsigned NUM_CHK        = 6,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               old_x,
  input  logic [2:0]               old_y,
  input  logic [2:0]               new_x,
  input  logic [2:0]               new_y,
  input  logic                     side_to_move,
  input  logic [7:0][7:0][3:0]     board_in,
  output logic [NUM_CHK-1:0]       chk_start,
  output logic [2:0]               chk_old_x,
  output logic [2:0]               chk_old_y,
  output logic [2:0]               chk_new_x,
  output logic [2:0]               chk_new_y,
  output logic [2:0]               chk_h_delta,
  output logic [2:0]               chk_v_delta,
  output logic [3:0]               chk_piece,
  input  logic [NUM_CHK-1:0]       chk_done,
  input  logic [NUM_CHK-1:0]       chk_legal,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic                     resp_legal,
  output logic [2:0]               resp_code
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_DISPATCH,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    ox_q, oy_q, nx_q, ny_q, hd_q, vd_q;
  logic [2:0]    ox_d, oy_d, nx_d, ny_d, hd_d, vd_d;
  logic [3:0]    piece_q, piece_d;
  logic [2:0]    sel_q, sel_d;
  logic          side_q, side_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          legal_q, legal_d;
  logic [2:0]    code_q, code_d;

  logic [3:0] src_w, dst_w;
  logic       src_empty, dst_empty, src_black, dst_black;

  assign src_w     = board_in[oy_q][ox_q];
  assign dst_w     = board_in[ny_q][nx_q];
  assign src_empty = (src_w >= 4'd12);
  assign dst_empty = (dst_w >= 4'd12);
  assign src_black = (src_w >= 4'd6);
  assign dst_black = (dst_w >= 4'd6);

`ifndef MOVE_SCHED_TURN_CHECK_EN
  logic side_unused;
  assign side_unused = side_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ox_q    <= '0;
      oy_q    <= '0;
      nx_q    <= '0;
      ny_q    <= '0;
      hd_q    <= '0;
      vd_q    <= '0;
      piece_q <= '0;
      sel_q   <= '0;
      side_q  <= 1'b0;
      cnt_q   <= '0;
      legal_q <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      nx_q    <= nx_d;
      ny_q    <= ny_d;
      hd_q    <= hd_d;
      vd_q    <= vd_d;
      piece_q <= piece_d;
      sel_q   <= sel_d;
      side_q  <= side_d;
      cnt_q   <= cnt_d;
      legal_q <= legal_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    nx_d    = nx_q;
    ny_d    = ny_q;
    hd_d    = hd_q;
    vd_d    = vd_q;
    piece_d = piece_q;
    sel_d   = sel_q;
    side_d  = side_q;
    cnt_d   = cnt_q;
    legal_d = legal_q;
    code_d  = code_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          ox_d    = old_x;
          oy_d    = old_y;
          nx_d    = new_x;
          ny_d    = new_y;
          side_d  = side_to_move;
          hd_d    = (new_x >= old_x) ? (new_x - old_x) : (old_x - new_x);
          vd_d    = (new_y >= old_y) ? (new_y - old_y) : (old_y - new_y);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // Pre-checks in priority order; the first hit becomes the verdict.
        legal_d = 1'b0;
        state_d = S_RESP;
        if (src_empty) begin
          code_d = 3'd1;
        end else if ((ox_q == nx_q) && (oy_q == ny_q)) begin
          code_d = 3'd2;
`ifdef MOVE_SCHED_TURN_CHECK_EN
        end else if (src_black != side_q) begin
          code_d = 3'd3;
`endif
        end else if (!dst_empty && (dst_black == src_black)) begin
          code_d = 3'd4;
        end else begin
          piece_d = src_w;
          sel_d   = src_black ? 3'(src_w - 4'd6) : src_w[2:0];
          state_d = S_DISPATCH;
        end
      end
      S_DISPATCH: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Done is tested first so it wins over a coincident timeout.
        if (chk_done[sel_q]) begin
          legal_d = chk_legal[sel_q];
          code_d  = 3'd0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          legal_d = 1'b0;
          code_d  = 3'd5;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready   = (state_q == S_IDLE);
    resp_valid  = (state_q == S_RESP);
    chk_start   = '0;
    if (state_q == S_DISPATCH) begin
      chk_start[sel_q] = 1'b1;
    end
    resp_legal  = legal_q;
    resp_code   = code_q;
    chk_old_x   = ox_q;
    chk_old_y   = oy_q;
    chk_new_x   = nx_q;
    chk_new_y   = ny_q;
    chk_h_delta = hd_q;
    chk_v_delta = vd_q;
    chk_piece   = piece_q;
  end

endmodule

// File: tb/tb_move_check_sched.sv
// Directed bench for move_check_sched; follows MOVE_SCHED_TURN_CHECK_EN for the wrong-turn case.
module tb_move_check_sched;

  localparam int TO = 8;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               req_valid;
  logic               req_ready;
  logic [2:0]         old_x, old_y, new_x, new_y;
  logic               side_to_move;
  logic [7:0][7:0][3:0] board;
  logic [5:0]         chk_start;
  logic [2:0]         chk_old_x, chk_old_y, chk_new_x, chk_new_y;
  logic [2:0]         chk_h_delta, chk_v_delta;
  logic [3:0]         chk_piece;
  logic [5:0]         chk_done, chk_legal;
  logic               resp_valid, resp_ready, resp_legal;
  logic [2:0]         resp_code;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  move_check_sched #(.NUM_CHK(6), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .old_x(old_x), .old_y(old_y), .new_x(new_x), .new_y(new_y),
    .side_to_move(side_to_move), .board_in(board),
    .chk_start(chk_start),
    .chk_old_x(chk_old_x), .chk_old_y(chk_old_y),
    .chk_new_x(chk_new_x), .chk_new_y(chk_new_y),
    .chk_h_delta(chk_h_delta), .chk_v_delta(chk_v_delta),
    .chk_piece(chk_piece),
    .chk_done(chk_done), .chk_legal(chk_legal),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_legal(resp_legal), .resp_code(resp_code)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_board;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        board[y][x] = 4'hF;
  endtask

  // Issues one request and plays the checker side; latency counts cycles from the accept cycle.
  task automatic run_move(input logic [2:0] ox, input logic [2:0] oy, input logic [2:0] nx,
                          input logic [2:0] ny, input logic side, input int done_idx,
                          input int done_dly, input logic legal, input int spur_idx,
                          output int lat, output int pulses, output logic [5:0] sv);
    int cyc;
    int sc;
    old_x = ox; old_y = oy; new_x = nx; new_y = ny;
    side_to_move = side;
    req_valid = 1'b1;
    pulses = 0; sv = '0; sc = -100; lat = 99;
    tick;
    req_valid = 1'b0;
    cyc = 1;
    while (cyc < 40) begin
      if (chk_start != '0) begin
        pulses++;
        sv = chk_start;
        sc = cyc;
      end
      chk_done = '0;
      chk_legal = '0;
      if (sc >= 0) begin
        if (spur_idx >= 0) begin
          chk_done[spur_idx] = 1'b1;
          chk_legal[spur_idx] = 1'b1;
        end
        if (done_idx >= 0 && cyc == sc + done_dly) begin
          chk_done[done_idx] = 1'b1;
          chk_legal[done_idx] = legal;
        end
      end
      if (resp_valid) begin
        lat = cyc;
        break;
      end
      tick;
      cyc++;
    end
    chk_done = '0;
    chk_legal = '0;
  endtask

  task automatic handshake;
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    chk("hs_resp_valid", 32'(resp_valid), 32'd0);
    chk("hs_req_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    int lat;
    int pulses;
    logic [5:0] sv;
    logic seen_bad;

    reset_n = 1'b0;
    req_valid = 1'b0; resp_ready = 1'b0;
    old_x = '0; old_y = '0; new_x = '0; new_y = '0;
    side_to_move = 1'b0;
    chk_done = '0; chk_legal = '0;
    clear_board();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_legal", 32'(resp_legal), 32'd0);
    chk("rst_resp_code", 32'(resp_code), 32'd0);
    chk("rst_chk_start", 32'(chk_start), 32'd0);
    chk("rst_chk_piece", 32'(chk_piece), 32'd0);
    chk("rst_h_delta", 32'(chk_h_delta), 32'd0);
    chk("rst_old_x", 32'(chk_old_x), 32'd0);
    reset_n = 1'b1;
    tick;

    // White rook (0,0)->(0,5), checker done+legal 2 cycles after start.
    board[0][0] = 4'd0;
    run_move(3'd0, 3'd0, 3'd0, 3'd5, 1'b0, 0, 2, 1'b1, -1, lat, pulses, sv);
    chk("rook_lat", 32'(lat), 32'd5);
    chk("rook_pulses", 32'(pulses), 32'd1);
    chk("rook_start", 32'(sv), 32'b000001);
    chk("rook_legal", 32'(resp_legal), 32'd1);
    chk("rook_code", 32'(resp_code), 32'd0);
    chk("rook_vdelta", 32'(chk_v_delta), 32'd5);
    chk("rook_hdelta", 32'(chk_h_delta), 32'd0);
    chk("rook_new_y", 32'(chk_new_y), 32'd5);
    chk("rook_piece", 32'(chk_piece), 32'd0);
    handshake();

    // Empty source square (3,3).
    run_move(3'd3, 3'd3, 3'd3, 3'd5, 1'b0, -1, 0, 1'b0, -1, lat, pulses, sv);
    chk("empty_lat", 32'(lat), 32'd2);
    chk("empty_pulses", 32'(pulses), 32'd0);
    chk("empty_legal", 32'(resp_legal), 32'd0);
    chk("empty_code", 32'(resp_code), 32'd1);
    handshake();

    // Code 13 on the source is treated as empty.
    board[2][2] = 4'd13;
    run_move(3'd2, 3'd2, 3'd2, 3'd3, 1'b0, -1, 0, 1'b0, -1, lat, pulses, sv);
    chk("code13_code", 32'(resp_code), 32'd1);
    chk("code13_pulses", 32'(pulses), 32'd0);
    handshake();

    // Null move.
    board[4][4] = 4'd0;
    run_move(3'd4, 3'd4, 3'd4, 3'd4, 1'b0, -1, 0, 1'b0, -1, lat, pulses, sv);
    chk("null_code", 32'(resp_code), 32'd2);
    chk("null_pulses", 32'(pulses), 32'd0);
    chk("null_lat", 32'(lat), 32'd2);
    handshake();

    // Black bishop (2,0)->(4,2) with white to move.
    clear_board();
    board[0][2] = 4'd8;
    run_move(3'd2, 3'd0, 3'd4, 3'd2, 1'b0, 2, 1, 1'b1, -1, lat, pulses, sv);
`ifdef MOVE_SCHED_TURN_CHECK_EN
    chk("turn_code", 32'(resp_code), 32'd3);
    chk("turn_legal", 32'(resp_legal), 32'd0);
    chk("turn_pulses", 32'(pulses), 32'd0);
    chk("turn_lat", 32'(lat), 32'd2);
`else
    chk("bishop_start", 32'(sv), 32'b000100);
    chk("bishop_pulses", 32'(pulses), 32'd1);
    chk("bishop_code", 32'(resp_code), 32'd0);
    chk("bishop_legal", 32'(resp_legal), 32'd1);
    chk("bishop_lat", 32'(lat), 32'd4);
    chk("bishop_piece", 32'(chk_piece), 32'd8);
`endif
    chk("bishop_hdelta", 32'(chk_h_delta), 32'd2);
    chk("bishop_vdelta", 32'(chk_v_delta), 32'd2);
    handshake();

    // White queen onto friendly pawn, then onto enemy pawn.
    clear_board();
    board[1][1] = 4'd3;
    board[4][1] = 4'd5;
    run_move(3'd1, 3'd1, 3'd1, 3'd4, 1'b0, 3, 1, 1'b1, -1, lat, pulses, sv);
    chk("friend_code", 32'(resp_code), 32'd4);
    chk("friend_pulses", 32'(pulses), 32'd0);
    handshake();
    board[4][1] = 4'd11;
    run_move(3'd1, 3'd1, 3'd1, 3'd4, 1'b0, 3, 3, 1'b0, -1, lat, pulses, sv);
    chk("queen_start", 32'(sv), 32'b001000);
    chk("queen_lat", 32'(lat), 32'd6);
    chk("queen_code", 32'(resp_code), 32'd0);
    chk("queen_legal", 32'(resp_legal), 32'd0);
    chk("queen_piece", 32'(chk_piece), 32'd3);
    handshake();

    // Knight checker never answers; rook index raises spurious done+legal.
    clear_board();
    board[0][6] = 4'd1;
    run_move(3'd6, 3'd0, 3'd5, 3'd2, 1'b0, -1, 0, 1'b0, 0, lat, pulses, sv);
    chk("to_start", 32'(sv), 32'b000010);
    chk("to_lat", 32'(lat), 32'(3 + TO));
    chk("to_code", 32'(resp_code), 32'd5);
    chk("to_legal", 32'(resp_legal), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("stall_valid", 32'(resp_valid), 32'd1);
      chk("stall_code", 32'(resp_code), 32'd5);
      chk("stall_legal", 32'(resp_legal), 32'd0);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
      chk("stall_new_x", 32'(chk_new_x), 32'd5);
    end
    handshake();

    // Reset while waiting on the king checker.
    clear_board();
    board[0][4] = 4'd4;
    old_x = 3'd4; old_y = 3'd0; new_x = 3'd4; new_y = 3'd1; side_to_move = 1'b0;
    req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    repeat (4) tick;
    reset_n = 1'b0;
    #1;
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    chk("abort_chk_start", 32'(chk_start), 32'd0);
    tick;
    reset_n = 1'b1;
    seen_bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (resp_valid || !req_ready) seen_bad = 1'b1;
    end
    chk("abort_no_resp", 32'(seen_bad), 32'd0);
    run_move(3'd4, 3'd0, 3'd4, 3'd1, 1'b0, 4, 1, 1'b1, -1, lat, pulses, sv);
    chk("king_start", 32'(sv), 32'b010000);
    chk("king_lat", 32'(lat), 32'd4);
    chk("king_legal", 32'(resp_legal), 32'd1);
    chk("king_code", 32'(resp_code), 32'd0);
    handshake();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/move_check_sched.md
Name: move_check_sched

Overview:
- Front-end scheduler for the board_validator piece checkers (rook, knight, bishop, queen, king, pawn).
- Accepts one move request at a time and decodes the moving piece from the board.
- Runs cheap pre-checks, then dispatches the move to exactly one checker with a one-cycle start pulse.
- Waits for that checker's done strobe, with a timeout, and returns a single verdict to game_play over a valid/ready response.

Parameters:
- NUM_CHK, 6, number of piece checkers; index = piece_code mod 6 (0 rook, 1 knight, 2 bishop, 3 queen, 4 king, 5 pawn).
- TIMEOUT_CYCLES, 64, maximum cycles spent in WAIT before forcing a timeout verdict.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  move request present.
- req_ready  out  1  scheduler can accept a request.
- old_x, old_y  in  3 each  source square.
- new_x, new_y  in  3 each  destination square.
- side_to_move  in  1  0 white, 1 black.
- board_in  in  4 per square, [8][8] indexed [y][x]  board state. Codes 0–5 white, 6–11 black, 15 empty.
- chk_start  out  NUM_CHK  one-hot, one-cycle start pulse to the selected checker.
- chk_old_x, chk_old_y, chk_new_x, chk_new_y  out  3 each  latched coordinates to the checkers.
- chk_h_delta, chk_v_delta  out  3 each  |new_x-old_x| and |new_y-old_y|.
- chk_piece  out  4  latched source piece code.
- chk_done  in  NUM_CHK  per-checker output-ready strobe.
- chk_legal  in  NUM_CHK  per-checker move-legal result, qualified by chk_done.
- resp_valid  out  1  verdict available.
- resp_ready  in  1  consumer accepts the verdict.
- resp_legal  out  1  1 = move legal.
- resp_code  out  3  0 checked, 1 empty source, 2 null move, 3 wrong turn, 4 friendly destination, 5 timeout.

Behaviour:
- Reset (asynchronous): state IDLE. req_ready=1. chk_start=0. resp_valid=0, resp_legal=0, resp_code=0. All latched coordinates, deltas and chk_piece =0. Timeout counter =0.
- Reset asserted mid-operation aborts the transaction immediately. No response is issued for the aborted request.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch coordinates and side_to_move, compute both deltas, go to DECODE.
- DECODE (1 cycle), req_ready=0. Read piece=board_in[old_y][old_x] and dest=board_in[new_y][new_x]. Pre-checks in priority order; the first match goes to RESP with resp_legal=0:
  1. piece==15 → code 1.
  2. old==new → code 2.
  3. piece color ≠ side_to_move → code 3.
  4. dest≠15 and same color as piece → code 4.
  5. Otherwise latch chk_piece, go to DISPATCH.
  - Piece codes 12–14 are treated as empty (code 1).
- DISPATCH (1 cycle): chk_start[piece mod 6]=1 for this cycle only. Clear the timeout counter. Go to WAIT.
- WAIT:
  - Sample only chk_done[sel]. Done/legal from non-selected checkers are ignored.
  - On chk_done[sel]: resp_legal=chk_legal[sel], code 0, go to RESP.
  - Otherwise increment the counter. When it reaches TIMEOUT_CYCLES-1 without done: resp_legal=0, code 5, go to RESP.
  - Done arriving on the same cycle as timeout expiry wins over the timeout.
- RESP:
  - resp_valid=1, with resp_legal and resp_code held stable until resp_ready.
  - On resp_valid&&resp_ready, go to IDLE (req_ready=1 on the next cycle). No back-to-back accept in the handshake cycle.
- Latency: accept→resp_valid is 2 cycles for pre-check rejects and 3+N for dispatched moves (N = checker cycles from start to done).
- The requester holds board_in stable from accept until response handshake. The block does not copy the board.
- chk_* coordinate, delta and piece outputs stay stable from DISPATCH through RESP.
- Only one transaction is in flight at a time. chk_start is never asserted outside DISPATCH.

Optional Feature:
- Macro: MOVE_SCHED_TURN_CHECK_EN.
- Defined: pre-check 3 (wrong turn, code 3) is active as specified above.
- Undefined: side_to_move is ignored and code 3 is never produced. Pre-checks 1, 2 and 4 are unchanged, so the friendly-destination check still uses the piece's own color.

Test Plan:
- White rook (0) at (0,0), empty path, move to (0,5), side 0, rook checker returns done+legal after 2 cycles → chk_start=6'b000001 for exactly 1 cycle, resp_legal=1, code 0, resp_valid 5 cycles after accept.
- Source square (3,3)=15 → no chk_start pulse, resp_legal=0, code 1, resp_valid 2 cycles after accept.
- Black bishop (8) at (2,0) → (4,2) with side_to_move=0 → code 3 with macro defined. With macro undefined: dispatch to index 2, result = checker verdict.
- White queen (3) → destination holding white pawn (5) → code 4, no dispatch. Destination holding black pawn (11) → dispatched to index 3.
- Selected checker never asserts done, with TIMEOUT_CYCLES=8 → code 5, resp_legal=0. Spurious chk_done on another index during WAIT is ignored. Then hold resp_ready=0 for 4 cycles → resp_valid and fields stay stable, req_ready=0 until handshake.
- Assert reset_n low during WAIT → next cycle state IDLE, req_ready=1, resp_valid=0, no response issued for the aborted request. A new request then completes normally.
